// File: rtl/rv32i_types.sv
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared rv32i types for the load/store unit: load/store
//                funct3 encodings, the access FSM state enum, and small
//                helpers for access size and funct3 legality.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  // Load funct3 encodings; LD and LWU exist only on a 64-bit datapath
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110
  } load_funct3_t;

  // Store funct3 encodings; SD exists only on a 64-bit datapath
  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010,
    ST_SD = 3'b011
  } store_funct3_t;

  // Load/store unit sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } mau_state_t;

  // Access size in bytes from the low two funct3 bits
  function automatic logic [3:0] access_size(input logic [2:0] funct3);
    logic [3:0] sz;
    case (funct3[1:0])
      2'b00:   sz = 4'd1;
      2'b01:   sz = 4'd2;
      2'b10:   sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

  // True when funct3 names a real load/store on this datapath width
  function automatic logic funct3_legal(input logic is_write,
                                        input logic [2:0] funct3,
                                        input logic xlen64);
    logic ok;
    ok = 1'b0;
    if (is_write) begin
      case (store_funct3_t'(funct3))
        ST_SB, ST_SH, ST_SW: ok = 1'b1;
        ST_SD:               ok = xlen64;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (load_funct3_t'(funct3))
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
        LD_LD, LD_LWU:                       ok = xlen64;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mau_lane_align.sv
// ============================================================================
//  Module      : mau_lane_align
//  Description : Combinational byte-lane logic for the load/store unit.
//                Builds byte enables and lane-shifted store data for either
//                half of a (possibly word-crossing) access, and extracts and
//                extends load data from the two-word byte-assembly register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_lane_align #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [OFFW-1:0]   i_off,
  input  logic [3:0]        i_size,
  input  logic              i_unsigned,
  input  logic              i_second,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [2*XLEN-1:0] i_asm,
  output logic [NB-1:0]     o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_load
);

  // The access is viewed as a window over two consecutive words: the low
  // half belongs to the first transaction, the high half to the second.
  logic [2*NB-1:0]   w_be_base;
  logic [2*NB-1:0]   w_be_full;
  logic [2*XLEN-1:0] w_wd_full;
  logic [XLEN-1:0]   w_raw;
  logic              w_sign;

  assign w_be_base = ((2*NB)'(1) << i_size) - (2*NB)'(1);
  assign w_be_full = w_be_base << i_off;
  assign w_wd_full = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};

  assign o_be    = i_second ? w_be_full[2*NB-1:NB]     : w_be_full[NB-1:0];
  assign o_wdata = i_second ? w_wd_full[2*XLEN-1:XLEN] : w_wd_full[XLEN-1:0];

  // Bring the first accessed byte down to lane 0
  assign w_raw = XLEN'(i_asm >> {i_off, 3'b000});

  // Keep the accessed bytes and fill the rest with sign or zero
  always_comb begin
    w_sign = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == int'(i_size) - 1) w_sign = w_raw[8*b+7];
    end
    o_load = '0;
    for (int b = 0; b < NB; b++) begin
      o_load[8*b +: 8] = (b < int'(i_size)) ? w_raw[8*b +: 8]
                                           : {8{w_sign & ~i_unsigned}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit. Accepts one request, issues one or two
//                word-aligned memory transactions with byte enables, waits
//                on the memory handshake and returns extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import rv32i_types::*;
#(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [XLEN-1:0]   mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_byte_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  mau_state_t        r_state;
  mau_state_t        w_next;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic              r_err;
  logic [2*XLEN-1:0] r_asm;

  logic [2:0]        w_funct3;
  logic              w_write;
  logic [OFFW-1:0]   w_off;
  logic [3:0]        w_size;
  logic              w_legal;
  logic              w_split;
  logic              w_bad;
  logic              w_accept;
  logic              w_in_acc;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_lane_wdata;
  logic [XLEN-1:0]   w_load;

  // In IDLE the decode looks at the incoming request so the error path can
  // reach RESP one cycle after acceptance; elsewhere it uses the latched copy.
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_write  = (r_state == IDLE) ? req_write  : r_write;
  assign w_off    = (r_state == IDLE) ? req_addr[OFFW-1:0] : r_addr[OFFW-1:0];
  assign w_size   = access_size(w_funct3);
  assign w_legal  = funct3_legal(w_write, w_funct3, XLEN == 64);
  assign w_split  = (5'(w_off) + 5'(w_size)) > 5'(NB);
  assign w_bad    = !w_legal || (w_split && !SPLIT_MISALIGNED);
  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_in_acc = (r_state == ACC0) || (r_state == ACC1);

  mau_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .i_off      (w_off),
    .i_size     (w_size),
    .i_unsigned (w_funct3[2]),
    .i_second   (r_state == ACC1),
    .i_wdata    (r_wdata),
    .i_asm      (r_asm),
    .o_be       (w_be),
    .o_wdata    (w_lane_wdata),
    .o_load     (w_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = w_bad ? RESP : ACC0;
      ACC0: if (mem_resp)  w_next = w_split ? ACC1 : RESP;
      ACC1: if (mem_resp)  w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = '0;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      ACC0, ACC1: begin
        mem_address     = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}}
                          + ((r_state == ACC1) ? XLEN'(NB) : XLEN'(0));
        mem_read        = !r_write;
        mem_write       = r_write;
        mem_byte_enable = w_be;
        mem_wdata       = w_lane_wdata;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_err || r_write) ? '0 : w_load;
      end
      default: ;
    endcase
  end

  // Request latch and load byte assembly; the second transaction's bytes
  // land in the upper word of the assembly register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_asm    <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
        r_write  <= req_write;
        r_err    <= w_bad;
        r_asm    <= '0;
      end
      if (mem_resp && w_in_acc && !r_write) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[b]) begin
            if (r_state == ACC1) r_asm[XLEN+8*b +: 8] <= mem_rdata[8*b +: 8];
            else                 r_asm[8*b +: 8]      <= mem_rdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit (XLEN=32). A bus
//                responder with random wait states backs the memory port; a
//                byte-array reference model predicts load results, errors
//                and transaction counts.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  mem_byte_enable;

  logic        ns_req_valid, ns_req_write;
  logic [2:0]  ns_req_funct3;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic        ns_req_ready, ns_resp_valid, ns_resp_err;
  logic [31:0] ns_resp_rdata, ns_mem_address, ns_mem_wdata, ns_mem_rdata;
  logic        ns_mem_read, ns_mem_write, ns_mem_resp;
  logic [3:0]  ns_mem_byte_enable;

  mem_access_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_access_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(ns_req_valid), .req_write(ns_req_write), .req_funct3(ns_req_funct3),
    .req_addr(ns_req_addr), .req_wdata(ns_req_wdata), .req_ready(ns_req_ready),
    .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
    .mem_address(ns_mem_address), .mem_read(ns_mem_read), .mem_write(ns_mem_write),
    .mem_byte_enable(ns_mem_byte_enable), .mem_wdata(ns_mem_wdata),
    .mem_rdata(ns_mem_rdata), .mem_resp(ns_mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus-side memory image and the architectural byte model
  logic [31:0] mem_words [0:255];
  logic [7:0]  ref_bytes [0:1023];

  task automatic poke(input int a, input logic [31:0] v);
    mem_words[a/4] = v;
    for (int k = 0; k < 4; k++) ref_bytes[a+k] = v[8*k +: 8];
  endtask

  function automatic int model_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_legal(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 <= 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int sz;
    logic [31:0] v;
    sz = model_size(f3);
    v  = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_bytes[a+k];
    if (!f3[2] && sz < 4 && v[8*sz-1]) begin
      for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
    int sz;
    sz = model_size(f3);
    for (int k = 0; k < sz; k++) ref_bytes[a+k] = wd[8*k +: 8];
  endtask

  // Memory responder: waits a number of cycles per transaction, then pulses mem_resp
  int fixed_wait = -1;
  bit force_resp = 1'b0;
  int rsp_cnt    = 0;
  bit rsp_active = 1'b0;

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp  = force_resp;
      mem_rdata = '0;
      if (rst || !(mem_read || mem_write)) begin
        rsp_active = 1'b0;
      end else begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (rsp_cnt == 0) begin
          mem_resp   = 1'b1;
          rsp_active = 1'b0;
          if (mem_read) begin
            mem_rdata = mem_words[mem_address[9:2]];
          end else begin
            for (int k = 0; k < 4; k++)
              if (mem_byte_enable[k]) mem_words[mem_address[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          end
        end else begin
          rsp_cnt--;
        end
      end
    end
  end

  // Observations from the most recent transaction
  int          n_acc, t_lat, t_last_resp;
  logic [31:0] acc_addr  [0:3];
  logic [3:0]  acc_be    [0:3];
  logic [31:0] acc_wdata [0:3];
  logic        acc_wr    [0:3];
  logic [31:0] t_rdata;
  logic        t_err, t_saw_rd, t_saw_wr, t_both, t_timeout, t_pulse_after;

  // Issue one request (called at a negedge) and observe it to completion.
  // With busy_poke set, a store request is offered while the unit is busy.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit busy_poke);
    int cyc;
    bit done;
    n_acc = 0; t_saw_rd = 0; t_saw_wr = 0; t_both = 0; t_timeout = 0;
    t_last_resp = -1; t_lat = 0; done = 0;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!done) begin
      if (mem_read)  t_saw_rd = 1'b1;
      if (mem_write) t_saw_wr = 1'b1;
      if (mem_read && mem_write) t_both = 1'b1;
      if (mem_resp && (mem_read || mem_write)) begin
        if (n_acc < 4) begin
          acc_addr[n_acc]  = mem_address;
          acc_be[n_acc]    = mem_byte_enable;
          acc_wdata[n_acc] = mem_wdata;
          acc_wr[n_acc]    = mem_write;
        end
        n_acc++;
        t_last_resp = cyc;
      end
      if (resp_valid) begin
        done = 1;
      end else if (cyc >= 40) begin
        t_timeout = 1'b1;
        done = 1;
      end else begin
        if (busy_poke && cyc == 1) begin
          req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
          req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        end else begin
          req_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    t_lat = cyc; t_rdata = resp_rdata; t_err = resp_err;
    req_valid = 1'b0;
    @(negedge clk);
    t_pulse_after = resp_valid;
  endtask

  initial begin : g_watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : g_main
    bit seen;
    logic [31:0] exp_rd;
    int bad_words;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    ns_req_valid = 1'b0; ns_req_write = 1'b0; ns_req_funct3 = '0; ns_req_addr = '0; ns_req_wdata = '0;
    ns_mem_rdata = '0; ns_mem_resp = 1'b0;
    for (int i = 0; i < 256; i++) poke(i*4, $urandom);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_outs_zero", 64'(|{resp_valid, resp_err, mem_read, mem_write, mem_address,
                                mem_byte_enable, mem_wdata, resp_rdata}), 64'(0));
    check("ns_rst_ready", 64'(ns_req_ready), 64'(1));
    check("ns_rst_zero", 64'(|{ns_resp_valid, ns_resp_err, ns_mem_read, ns_mem_write, ns_mem_address,
                              ns_mem_byte_enable, ns_mem_wdata, ns_resp_rdata}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // LW 0x100 with two wait cycles
    poke(32'h100, 32'hDEADBEEF);
    fixed_wait = 2;
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
    check("lw_rdata", 64'(t_rdata), 64'h0000_0000_DEAD_BEEF);
    check("lw_err", 64'(t_err), 64'(0));
    check("lw_addr", 64'(acc_addr[0]), 64'h100);
    check("lw_be", 64'(acc_be[0]), 64'hF);
    check("lw_nacc", 64'(n_acc), 64'(1));
    check("lw_lat", 64'(t_lat), 64'(4));
    check("lw_resp_after_mem", 64'(t_lat - t_last_resp), 64'(1));
    check("lw_pulse", 64'(t_pulse_after), 64'(0));

    // LB / LBU 0x103, zero-wait
    poke(32'h100, 32'h80FF_FFFF);
    fixed_wait = 0;
    do_req(1'b0, 3'd0, 32'h103, 32'h0, 1'b0);
    check("lb_be", 64'(acc_be[0]), 64'h8);
    check("lb_rdata", 64'(t_rdata), 64'hFFFF_FF80);
    check("lb_lat", 64'(t_lat), 64'(2));
    do_req(1'b0, 3'd4, 32'h103, 32'h0, 1'b0);
    check("lbu_rdata", 64'(t_rdata), 64'h0000_0080);
    check("lbu_lat", 64'(t_lat), 64'(2));

    // SH 0x102
    fixed_wait = -1;
    do_req(1'b1, 3'd1, 32'h102, 32'h0000_1234, 1'b0);
    model_store(3'd1, 32'h102, 32'h0000_1234);
    check("sh_write", 64'(acc_wr[0]), 64'(1));
    check("sh_noread", 64'(t_saw_rd), 64'(0));
    check("sh_be", 64'(acc_be[0]), 64'hC);
    check("sh_wdata_hi", 64'(acc_wdata[0][31:16]), 64'h1234);
    check("sh_rdata", 64'(t_rdata), 64'(0));
    check("sh_err", 64'(t_err), 64'(0));
    exp_rd = model_load(3'd2, 32'h100);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
    check("sh_readback", 64'(t_rdata), 64'(exp_rd));

    // Split LW 0x206
    poke(32'h204, 32'hBBAA_0000);
    poke(32'h208, 32'h0000_DDCC);
    do_req(1'b0, 3'd2, 32'h206, 32'h0, 1'b0);
    check("split_nacc", 64'(n_acc), 64'(2));
    check("split_addr0", 64'(acc_addr[0]), 64'h204);
    check("split_be0", 64'(acc_be[0]), 64'hC);
    check("split_addr1", 64'(acc_addr[1]), 64'h208);
    check("split_be1", 64'(acc_be[1]), 64'h3);
    check("split_rdata", 64'(t_rdata), 64'hDDCC_BBAA);
    check("split_resp_after_mem", 64'(t_lat - t_last_resp), 64'(1));

    // Illegal funct3
    do_req(1'b0, 3'd3, 32'h100, 32'h0, 1'b0);
    check("ill_ld_err", 64'(t_err), 64'(1));
    check("ill_ld_lat", 64'(t_lat), 64'(1));
    check("ill_ld_nomem", 64'(t_saw_rd | t_saw_wr), 64'(0));
    check("ill_ld_rdata", 64'(t_rdata), 64'(0));
    do_req(1'b1, 3'd3, 32'h100, 32'h0, 1'b0);
    check("ill_st_err", 64'(t_err), 64'(1));
    check("ill_st_nomem", 64'(t_saw_rd | t_saw_wr), 64'(0));

    // Request offered while busy is ignored
    fixed_wait = 3;
    exp_rd = model_load(3'd2, 32'h100);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 1'b1);
    check("busy_rdata", 64'(t_rdata), 64'(exp_rd));
    check("busy_nowrite", 64'(t_saw_wr), 64'(0));
    check("busy_nacc", 64'(n_acc), 64'(1));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_write) seen = 1'b1;
    end
    check("busy_no_extra", 64'(seen), 64'(0));

    // Reset during ACC0, then a stray mem_resp
    fixed_wait = 20;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_acc0_read", 64'(mem_read), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_read", 64'(mem_read), 64'(0));
    check("rst_mid_ready", 64'(req_ready), 64'(1));
    check("rst_mid_zero", 64'(|{resp_valid, resp_err, mem_write, mem_address,
                               mem_byte_enable, mem_wdata, resp_rdata}), 64'(0));
    @(negedge clk);
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst_late_resp", 64'(seen), 64'(0));
    fixed_wait = -1;

    // SPLIT_MISALIGNED=0: word-crossing LW errors at T+1 without memory access
    ns_req_valid = 1'b1; ns_req_write = 1'b0; ns_req_funct3 = 3'd2; ns_req_addr = 32'h206;
    @(negedge clk);
    ns_req_valid = 1'b0;
    check("ns_resp", 64'({ns_resp_valid, ns_resp_err}), 64'h3);
    check("ns_noread", 64'(ns_mem_read | ns_mem_write), 64'(0));
    @(negedge clk);
    check("ns_idle", 64'({ns_resp_valid, ns_req_ready}), 64'h1);

    // Randomized traffic against the byte model
    for (int i = 0; i < 80; i++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] wd;
      int          a, sz, exp_n;
      bit          legal, split;
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      a     = int'($urandom_range(0, 1015));
      wd    = $urandom;
      sz    = model_size(f3);
      legal = model_legal(wr, f3);
      split = ((a % 4) + sz) > 4;
      exp_rd = (legal && !wr) ? model_load(f3, a) : 32'h0;
      exp_n  = legal ? (split ? 2 : 1) : 0;
      do_req(wr, f3, 32'(a), wd, 1'b0);
      if (legal && wr) model_store(f3, a, wd);
      check("rnd_err", 64'(t_err), 64'(!legal));
      check("rnd_rdata", 64'(t_rdata), 64'(exp_rd));
      check("rnd_nacc", 64'(n_acc), 64'(exp_n));
      if (legal) begin
        check("rnd_addr0", 64'(acc_addr[0]), 64'(a & ~3));
        check("rnd_lat", 64'(t_lat), 64'(t_last_resp + 1));
      end else begin
        check("rnd_lat_err", 64'(t_lat), 64'(1));
      end
      check("rnd_excl", 64'(t_both), 64'(0));
      check("rnd_pulse", 64'(t_pulse_after), 64'(0));
      check("rnd_timeout", 64'(t_timeout), 64'(0));
    end

    // Memory image written over the bus must match the byte model
    bad_words = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_words[i] !== {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]})
        bad_words++;
    end
    check("mem_image", 64'(bad_words), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit replacing the fixed MAR/MDR/MEM_DATA_OUT register trio of the multicycle rv32i datapath.
- Accepts one load/store request from control and generates word-aligned memory accesses with byte enables.
- Waits on the memory handshake and returns aligned, sign/zero-extended load data.
- Optionally splits misaligned accesses into two memory transactions.

Parameters:
XLEN, 32, data/address width; must be 32 or 64.
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses into two transactions; 0 = flag them as errors.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
req_valid  in  1  request strobe; sampled only while req_ready=1
req_write  in  1  1=store, 0=load
req_funct3  in  3  rv32i load/store funct3
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified
req_ready  out  1  unit idle and able to accept a request
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: illegal funct3, or misaligned with SPLIT_MISALIGNED=0
mem_address  out  XLEN  word-aligned address (low log2(XLEN/8) bits are 0)
mem_read  out  1  read request; held until mem_resp
mem_write  out  1  write request; held until mem_resp
mem_byte_enable  out  XLEN/8  active byte lanes
mem_wdata  out  XLEN  lane-shifted store data
mem_rdata  in  XLEN  read data; valid while mem_resp=1
mem_resp  in  1  memory completion; honoured only in ACC0/ACC1

Behaviour:
- After reset:
  - state IDLE; req_ready=1.
  - resp_valid, resp_err, mem_read, mem_write = 0.
  - mem_address, mem_byte_enable, mem_wdata, resp_rdata = 0.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches addr, funct3, write and wdata.
  - Decode on the latched request: NB=XLEN/8, off=addr mod NB, size=1/2/4 (8 only when XLEN=64, funct3 3).
  - Illegal funct3 (load 3,6,7 at XLEN=32; store >=3 at XLEN=32) -> RESP with err and no memory access.
  - Word-crossing access (off+size>NB) with SPLIT_MISALIGNED=0 -> RESP with err and no memory access.
  - Otherwise -> ACC0.
- ACC0:
  - mem_address = addr with low bits cleared.
  - mem_byte_enable = ((1<<size)-1)<<off, truncated to NB bits.
  - mem_wdata = wdata << 8*off.
  - mem_read or mem_write held high.
  - On mem_resp: if split -> ACC1, else -> RESP. mem_resp may arrive in the first cycle (zero-wait).
- ACC1 (split only):
  - mem_address = previous word + NB.
  - mem_byte_enable = remaining low lanes.
  - mem_wdata = wdata >> 8*(NB-off).
  - On mem_resp -> RESP.
- Loads:
  - The enabled bytes of each response are captured into an internal byte-assembly register.
  - The result is shifted down and sign-extended (LB/LH/LW at XLEN=64) or zero-extended (LBU/LHU/LWU).
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata/resp_err valid in the same cycle.
  - mem_read/mem_write low.
  - Next state IDLE.
- Latency:
  - Accept in cycle T -> mem_read/mem_write rise in T+1.
  - First mem_resp in cycle R -> resp_valid in R+1 (non-split) or ACC1 starts in R+1 (split).
  - Error path: resp_valid in T+1.
- req_valid while req_ready=0 is ignored; no queueing.
- mem_resp in IDLE or RESP is ignored.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. A late mem_resp produces no resp_valid.
- mem_read and mem_write are never high in the same cycle. Both drop in the cycle after the final mem_resp.

Decomposition:
- Add to rv32i_types:
  - load_funct3_t / store_funct3_t enums, including lwu/ld/sd codes for XLEN=64.
  - mau_state_t enum {IDLE, ACC0, ACC1, RESP}.
- Sub-module mau_lane_align: purely combinational. It covers byte-enable generation, store-lane shifting and load extraction/extension, and is shared by both ACC states. The FSM and registers stay in mem_access_unit.

Test Plan:
- LW 0x100, mem_resp after 2 wait cycles with mem_rdata 0xDEADBEEF -> mem_address 0x100, be 4'hF, resp_rdata 0xDEADBEEF, resp_valid exactly 1 cycle after mem_resp.
- LB 0x103, mem_rdata 0x80FFFFFF -> be 4'b1000, resp_rdata 0xFFFFFF80; same request as LBU -> 0x00000080; zero-wait mem_resp -> resp_valid at T+2.
- SH 0x102, wdata 0x00001234 -> mem_write=1, be 4'b1100, mem_wdata[31:16]=0x1234, resp_rdata 0, resp_err 0.
- LW 0x206 with SPLIT=1:
  - first access 0x204, be 4'b1100, rdata 0xBBAA0000;
  - second access 0x208, be 4'b0011, rdata 0x0000DDCC;
  - -> resp_rdata 0xDDCCBBAA.
  - With SPLIT=0 -> resp_err=1 at T+1 and mem_read never asserted.
- Load with funct3 3'b011 at XLEN=32 -> resp_valid and resp_err at T+1, no mem_read; req_valid pulsed during ACC0 is ignored.
- rst asserted in ACC0 with mem_read high -> next cycle mem_read=0, req_ready=1; a mem_resp two cycles later gives no resp_valid.
